bomb_timer: RTL and testbench

BOMB_TIMER -- requirements
Module: bomb_timer

---
 rtl/bomb_timer.sv | 111 +++++++++++
 tb/tb_bomb_timer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/bomb_timer.sv
// Bomb placement timer: arms a fuse, holds the blast window, then cools down.
// Position is latched at placement and held until the next accepted placement.
module bomb_timer #(
  parameter int unsigned FUSE_TICKS     = 150000000,
  parameter int unsigned BLAST_TICKS    = 25000000,
  parameter int unsigned COOLDOWN_TICKS = 50000000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       place,
  input  logic       stunned,
  input  logic [5:0] posX,
  input  logic [5:0] posY,
  output logic [5:0] bombPosX,
  output logic [5:0] bombPosY,
  output logic       bombActive,
  output logic       bombExploded,
  output logic       explodePulse,
  output logic       ready
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    EXPLODE,
    COOLDOWN
  } state_t;

  localparam logic [27:0] FUSE_LOAD  = 28'(FUSE_TICKS - 1);
  localparam logic [27:0] BLAST_LOAD = 28'(BLAST_TICKS - 1);
  localparam logic [27:0] COOL_LOAD  = 28'(COOLDOWN_TICKS - 1);

  state_t      state;
  logic [27:0] cnt;
  logic        place_q;
  logic        primed;
  logic        rise;
  logic        cntZero;

  // The first edge after reset only samples place, so a level
  // already high when reset releases cannot count as a new press.
  assign rise    = place & ~place_q & primed;
  assign cntZero = (cnt == 28'd0);

  // Edge detector history and post-reset priming flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      place_q <= 1'b0;
      primed  <= 1'b0;
    end else begin
      place_q <= place;
      primed  <= 1'b1;
    end
  end

  // Main sequence: placement, fuse, blast window, cooldown.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      cnt          <= 28'd0;
      bombPosX     <= 6'd0;
      bombPosY     <= 6'd0;
      explodePulse <= 1'b0;
    end else begin
      explodePulse <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rise && !stunned) begin
            state    <= ARMED;
            cnt      <= FUSE_LOAD;
            bombPosX <= posX;
            bombPosY <= posY;
          end
        end
        ARMED: begin
          if (cntZero) begin
            state        <= EXPLODE;
            cnt          <= BLAST_LOAD;
            explodePulse <= 1'b1;
          end else begin
            cnt <= cnt - 28'd1;
          end
        end
        EXPLODE: begin
          if (cntZero) begin
            state <= COOLDOWN;
            cnt   <= COOL_LOAD;
          end else begin
            cnt <= cnt - 28'd1;
          end
        end
        COOLDOWN: begin
          if (cntZero) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 28'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 28'd0;
        end
      endcase
    end
  end

  assign bombActive   = (state == ARMED) || (state == EXPLODE);
  assign bombExploded = (state == EXPLODE);
  assign ready        = (state == IDLE);

endmodule

// File: tb/tb_bomb_timer.sv
// Directed bench for bomb_timer with short fuse/blast/cooldown.
// Inputs change on falling edges; outputs are sampled there too.
module tb_bomb_timer;

  logic       clk;
  logic       resetn;
  logic       place;
  logic       stunned;
  logic [5:0] posX;
  logic [5:0] posY;
  logic [5:0] bombPosX;
  logic [5:0] bombPosY;
  logic       bombActive;
  logic       bombExploded;
  logic       explodePulse;
  logic       ready;

  int checks = 0;
  int errors = 0;

  bomb_timer #(
    .FUSE_TICKS(4),
    .BLAST_TICKS(2),
    .COOLDOWN_TICKS(3)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .place(place),
    .stunned(stunned),
    .posX(posX),
    .posY(posY),
    .bombPosX(bombPosX),
    .bombPosY(bombPosY),
    .bombActive(bombActive),
    .bombExploded(bombExploded),
    .explodePulse(explodePulse),
    .ready(ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chkIdle(input string tag, input logic [5:0] ex,
                         input logic [5:0] ey);
    chk({tag, " ready"}, 32'(ready), 32'd1);
    chk({tag, " active"}, 32'(bombActive), 32'd0);
    chk({tag, " exploded"}, 32'(bombExploded), 32'd0);
    chk({tag, " pulse"}, 32'(explodePulse), 32'd0);
    chk({tag, " posX"}, 32'(bombPosX), 32'(ex));
    chk({tag, " posY"}, 32'(bombPosY), 32'(ey));
  endtask

  // Caller raises place at a falling edge; the next rising edge is
  // edge 0 and the falling edge after it is cycle 1.
  task automatic runBomb(input string name, input logic [5:0] ex,
                         input logic [5:0] ey, input bit moveArmed,
                         input bit stunToggle, input bit coolRise);
    string t;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      t = $sformatf("%s c%0d", name, c);
      chk({t, " active"}, 32'(bombActive), 32'((c >= 1) && (c <= 6)));
      chk({t, " exploded"}, 32'(bombExploded), 32'((c == 5) || (c == 6)));
      chk({t, " pulse"}, 32'(explodePulse), 32'(c == 5));
      chk({t, " ready"}, 32'(ready), 32'(c >= 10));
      chk({t, " posX"}, 32'(bombPosX), 32'(ex));
      chk({t, " posY"}, 32'(bombPosY), 32'(ey));
      if (moveArmed && c == 2) begin
        posX = 6'd11;
        posY = 6'd8;
      end
      if (stunToggle && c == 2) stunned = 1'b1;
      if (stunToggle && c == 7) stunned = 1'b0;
      if (coolRise) begin
        if (c == 6) place = 1'b0;
        if (c == 7) place = 1'b1;
        if (c == 8) place = 1'b0;
        if (c == 9) place = 1'b1;
      end
    end
  endtask

  initial begin
    resetn  = 1'b0;
    place   = 1'b0;
    stunned = 1'b0;
    posX    = 6'd0;
    posY    = 6'd0;

    repeat (2) @(negedge clk);
    chkIdle("reset", 6'd0, 6'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    chkIdle("postReset", 6'd0, 6'd0);

    // Basic bomb, position moved during fuse, place held high throughout.
    posX  = 6'd10;
    posY  = 6'd7;
    place = 1'b1;
    runBomb("basic", 6'd10, 6'd7, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chkIdle($sformatf("held%0d", i), 6'd10, 6'd7);
    end

    // Stunned rise rejected and not queued.
    place = 1'b0;
    @(negedge clk);
    stunned = 1'b1;
    place   = 1'b1;
    repeat (2) @(negedge clk);
    chkIdle("stunRise", 6'd10, 6'd7);
    stunned = 1'b0;
    @(negedge clk);
    chkIdle("stunClear", 6'd10, 6'd7);
    place = 1'b0;
    @(negedge clk);

    // Accepted rise; stun mid-sequence; rises in cooldown and on exit.
    posX  = 6'd20;
    posY  = 6'd30;
    place = 1'b1;
    runBomb("coolRise", 6'd20, 6'd30, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    chkIdle("afterCool", 6'd20, 6'd30);

    // Fresh rise in idle after the ignored ones is accepted.
    place = 1'b0;
    @(negedge clk);
    posX  = 6'd5;
    posY  = 6'd6;
    place = 1'b1;
    runBomb("fresh", 6'd5, 6'd6, 1'b0, 1'b0, 1'b0);

    // Reset pulsed during the blast window aborts asynchronously.
    place = 1'b0;
    @(negedge clk);
    posX  = 6'd33;
    posY  = 6'd44;
    place = 1'b1;
    repeat (5) @(negedge clk);
    chk("preAbort pulse", 32'(explodePulse), 32'd1);
    chk("preAbort exploded", 32'(bombExploded), 32'd1);
    #2 resetn = 1'b0;
    #1;
    chkIdle("abort", 6'd0, 6'd0);
    @(negedge clk);
    chkIdle("abortHeld", 6'd0, 6'd0);
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chkIdle($sformatf("release%0d", i), 6'd0, 6'd0);
    end
    place = 1'b0;
    @(negedge clk);
    place = 1'b1;
    @(negedge clk);
    chk("reArm active", 32'(bombActive), 32'd1);
    chk("reArm ready", 32'(ready), 32'd0);
    chk("reArm posX", 32'(bombPosX), 32'd33);
    chk("reArm posY", 32'(bombPosY), 32'd44);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
